// File: rtl/apb_cfg_regs_if.sv
// ---------------------------------------------------------------------------
// apb_cfg_regs_if
// APB3 bus bundle between the APB master and the aligner configuration
// register file. The clock and reset are not part of the bundle; they stay
// as plain ports on the modules.
//
//   paddr    master -> completer   transfer address
//   psel     master -> completer   completer select
//   penable  master -> completer   access phase marker
//   pwrite   master -> completer   1 = write, 0 = read
//   pwdata   master -> completer   write data
//   pready   completer -> master   transfer complete
//   prdata   completer -> master   read data, valid with pready
//   pslverr  completer -> master   error response, valid with pready
// ---------------------------------------------------------------------------
interface apb_cfg_regs_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] paddr;
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [DATA_WIDTH-1:0] pwdata;
    logic                  pready;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_cfg_regs.sv
// ---------------------------------------------------------------------------
// apb_cfg_regs
// APB3 completer holding the aligner configuration/status registers:
//   0x0000 CTRL   RW  [2:0] SIZE (reset 1), [9:8] OFFSET, [16] CLR (write-only)
//   0x000C STATUS RO  [7:0] cnt_drop, [11:8] rx_lvl, [27:24] tx_lvl
//   0x00F0 IRQEN  RW  [4:0]
//   0x00F4 IRQ    W1C [4:0] sticky event flags
// Each transfer takes WAIT_STATES extra access cycles before pready.
//
// Ports:
//   clk          in   clock, all logic on the rising edge
//   preset_n     in   asynchronous active-low reset
//   apb          slave modport of apb_cfg_regs_if (APB3 transfer signals)
//   ctrl_size    out  CTRL.SIZE
//   ctrl_offset  out  CTRL.OFFSET
//   ctrl_clr     out  one-cycle pulse after a CTRL write with bit 16 set
//   sts_cnt_drop in   drop counter from the core
//   sts_rx_lvl   in   receive FIFO level
//   sts_tx_lvl   in   transmit FIFO level
//   irq_evt      in   event pulses {max_drop, tx_full, tx_empty, rx_full, rx_empty}
//   irq          out  registered OR of enabled pending flags
// ---------------------------------------------------------------------------
module apb_cfg_regs #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 32,   // only 32 is supported
    parameter int WAIT_STATES = 0     // 0..15
) (
    input  logic                clk,
    input  logic                preset_n,
    apb_cfg_regs_if.slave       apb,
    output logic [2:0]          ctrl_size,
    output logic [1:0]          ctrl_offset,
    output logic                ctrl_clr,
    input  logic [7:0]          sts_cnt_drop,
    input  logic [3:0]          sts_rx_lvl,
    input  logic [3:0]          sts_tx_lvl,
    input  logic [4:0]          irq_evt,
    output logic                irq
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_CTRL   = ADDR_WIDTH'('h0000);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STATUS = ADDR_WIDTH'('h000C);
    localparam logic [ADDR_WIDTH-1:0] ADDR_IRQEN  = ADDR_WIDTH'('h00F0);
    localparam logic [ADDR_WIDTH-1:0] ADDR_IRQ    = ADDR_WIDTH'('h00F4);
    localparam logic [3:0]            WAIT_LOAD   = 4'(WAIT_STATES);

    typedef enum logic {
        S_IDLE,
        S_ACCESS
    } state_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t                 state_reg, state_next;
    logic [3:0]             wait_cnt_reg, wait_cnt_next;
    logic                   pready_reg, pready_next;
    logic                   pslverr_reg, pslverr_next;
    logic [DATA_WIDTH-1:0]  prdata_reg, prdata_next;

    // Transfer context captured in the setup cycle
    logic                   wr_reg, wr_next;
    logic                   err_reg, err_next;
    logic [2:0]             sel_reg, sel_next;      // {IRQ, IRQEN, CTRL}
    logic [2:0]             wsize_reg, wsize_next;
    logic [1:0]             woffset_reg, woffset_next;
    logic                   wclr_reg, wclr_next;
    logic [4:0]             wbits_reg, wbits_next;

    // Register file
    logic [2:0]             size_reg;
    logic [1:0]             offset_reg;
    logic                   clr_reg;
    logic [4:0]             irqen_reg;
    logic [4:0]             irq_flag_reg, irq_flag_next;
    logic                   irq_reg;

    logic                   commit;
    logic                   commit_ctrl, commit_irqen, commit_irq;
    logic [4:0]             w1c_mask;

    // -----------------------------------------------------------------------
    // Address decode and error classification (setup-cycle view)
    // -----------------------------------------------------------------------
    logic hit_ctrl, hit_status, hit_irqen, hit_irq;
    logic ctrl_wdata_ok;
    logic wr_err, rd_err;
    logic [DATA_WIDTH-1:0] rdata_mux;

    assign hit_ctrl   = (apb.paddr == ADDR_CTRL);
    assign hit_status = (apb.paddr == ADDR_STATUS);
    assign hit_irqen  = (apb.paddr == ADDR_IRQEN);
    assign hit_irq    = (apb.paddr == ADDR_IRQ);

    // SIZE must be non-zero and the SIZE+OFFSET window must fit in 4 lanes.
    assign ctrl_wdata_ok = (apb.pwdata[2:0] != 3'd0) &&
                           (({1'b0, apb.pwdata[2:0]} + {2'b00, apb.pwdata[9:8]}) <= 4'd4);

    assign wr_err = !(hit_ctrl || hit_irqen || hit_irq) || (hit_ctrl && !ctrl_wdata_ok);
    assign rd_err = !(hit_ctrl || hit_status || hit_irqen || hit_irq);

    // Read data is snapshotted at the setup edge, so STATUS reflects the
    // core inputs in the setup cycle regardless of later changes.
    always_comb begin
        rdata_mux = '0;
        if (hit_ctrl) begin
            rdata_mux[2:0] = size_reg;
            rdata_mux[9:8] = offset_reg;
        end
        if (hit_status) begin
            rdata_mux[7:0]   = sts_cnt_drop;
            rdata_mux[11:8]  = sts_rx_lvl;
            rdata_mux[27:24] = sts_tx_lvl;
        end
        if (hit_irqen) begin
            rdata_mux[4:0] = irqen_reg;
        end
        if (hit_irq) begin
            rdata_mux[4:0] = irq_flag_reg;
        end
    end

    // -----------------------------------------------------------------------
    // Transfer FSM: next state / outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        pready_next   = 1'b0;
        pslverr_next  = pslverr_reg;
        prdata_next   = prdata_reg;
        wr_next       = wr_reg;
        err_next      = err_reg;
        sel_next      = sel_reg;
        wsize_next    = wsize_reg;
        woffset_next  = woffset_reg;
        wclr_next     = wclr_reg;
        wbits_next    = wbits_reg;
        commit        = 1'b0;

        case (state_reg)
            S_IDLE: begin
                prdata_next  = '0;
                pslverr_next = 1'b0;
                if (apb.psel && !apb.penable) begin
                    wr_next       = apb.pwrite;
                    err_next      = apb.pwrite ? wr_err : rd_err;
                    sel_next      = {hit_irq, hit_irqen, hit_ctrl};
                    wsize_next    = apb.pwdata[2:0];
                    woffset_next  = apb.pwdata[9:8];
                    wclr_next     = apb.pwdata[16];
                    wbits_next    = apb.pwdata[4:0];
                    wait_cnt_next = WAIT_LOAD;
                    // pready is registered, so with no wait states it must
                    // already be scheduled at the setup edge.
                    pready_next   = (WAIT_LOAD == 4'd0);
                    pslverr_next  = apb.pwrite ? wr_err : rd_err;
                    prdata_next   = (!apb.pwrite && !rd_err) ? rdata_mux : '0;
                    state_next    = S_ACCESS;
                end
            end

            S_ACCESS: begin
                if (!(apb.psel && apb.penable)) begin
                    // Master abandoned the transfer: drop it silently.
                    state_next    = S_IDLE;
                    wait_cnt_next = 4'd0;
                    prdata_next   = '0;
                    pslverr_next  = 1'b0;
                end else if (pready_reg) begin
                    // Completion edge: writes take effect here.
                    commit       = wr_reg && !err_reg;
                    state_next   = S_IDLE;
                    prdata_next  = '0;
                    pslverr_next = 1'b0;
                end else if (wait_cnt_reg != 4'd0) begin
                    wait_cnt_next = wait_cnt_reg - 4'd1;
                    pready_next   = (wait_cnt_reg == 4'd1);
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge preset_n) begin
        if (!preset_n) begin
            state_reg    <= S_IDLE;
            wait_cnt_reg <= 4'd0;
            pready_reg   <= 1'b0;
            pslverr_reg  <= 1'b0;
            prdata_reg   <= '0;
            wr_reg       <= 1'b0;
            err_reg      <= 1'b0;
            sel_reg      <= 3'd0;
            wsize_reg    <= 3'd0;
            woffset_reg  <= 2'd0;
            wclr_reg     <= 1'b0;
            wbits_reg    <= 5'd0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            pready_reg   <= pready_next;
            pslverr_reg  <= pslverr_next;
            prdata_reg   <= prdata_next;
            wr_reg       <= wr_next;
            err_reg      <= err_next;
            sel_reg      <= sel_next;
            wsize_reg    <= wsize_next;
            woffset_reg  <= woffset_next;
            wclr_reg     <= wclr_next;
            wbits_reg    <= wbits_next;
        end
    end

    // -----------------------------------------------------------------------
    // Register file
    // -----------------------------------------------------------------------
    assign commit_ctrl  = commit && sel_reg[0];
    assign commit_irqen = commit && sel_reg[1];
    assign commit_irq   = commit && sel_reg[2];
    assign w1c_mask     = commit_irq ? wbits_reg : 5'd0;

    // A new event in the same cycle as its W1C clear keeps the flag set.
    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_irq_flag
            assign irq_flag_next[gi] = irq_evt[gi] | (irq_flag_reg[gi] & ~w1c_mask[gi]);
        end
    endgenerate

    always_ff @(posedge clk or negedge preset_n) begin
        if (!preset_n) begin
            size_reg     <= 3'd1;
            offset_reg   <= 2'd0;
            clr_reg      <= 1'b0;
            irqen_reg    <= 5'd0;
            irq_flag_reg <= 5'd0;
            irq_reg      <= 1'b0;
        end else begin
            if (commit_ctrl) begin
                size_reg   <= wsize_reg;
                offset_reg <= woffset_reg;
            end
            clr_reg <= commit_ctrl && wclr_reg;
            if (commit_irqen) begin
                irqen_reg <= wbits_reg;
            end
            irq_flag_reg <= irq_flag_next;
            irq_reg      <= |(irq_flag_reg & irqen_reg);
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign apb.pready  = pready_reg;
    assign apb.prdata  = prdata_reg;
    assign apb.pslverr = pslverr_reg;
    assign ctrl_size   = size_reg;
    assign ctrl_offset = offset_reg;
    assign ctrl_clr    = clr_reg;
    assign irq         = irq_reg;

endmodule

// File: tb/tb_apb_cfg_regs.sv
module tb_apb_cfg_regs;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        preset_n;
    logic [15:0] m_paddr;
    logic        m_psel, m_penable, m_pwrite;
    logic [31:0] m_pwdata;
    logic [7:0]  sts_cnt_drop;
    logic [3:0]  sts_rx_lvl, sts_tx_lvl;
    logic [4:0]  irq_evt;
    int          dut_sel = 0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    apb_cfg_regs_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus0(), bus2(), bus3();

    assign bus0.paddr = m_paddr;  assign bus2.paddr = m_paddr;  assign bus3.paddr = m_paddr;
    assign bus0.pwrite = m_pwrite; assign bus2.pwrite = m_pwrite; assign bus3.pwrite = m_pwrite;
    assign bus0.pwdata = m_pwdata; assign bus2.pwdata = m_pwdata; assign bus3.pwdata = m_pwdata;
    assign bus0.penable = m_penable; assign bus2.penable = m_penable; assign bus3.penable = m_penable;
    assign bus0.psel = m_psel && (dut_sel == 0);
    assign bus2.psel = m_psel && (dut_sel == 2);
    assign bus3.psel = m_psel && (dut_sel == 3);

    logic [2:0] size0, size2, size3;
    logic [1:0] offset0, offset2, offset3;
    logic       clr0, clr2, clr3, irq0, irq2, irq3;

    apb_cfg_regs #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .WAIT_STATES(0)) dut0 (
        .clk(clk), .preset_n(preset_n), .apb(bus0),
        .ctrl_size(size0), .ctrl_offset(offset0), .ctrl_clr(clr0),
        .sts_cnt_drop(sts_cnt_drop), .sts_rx_lvl(sts_rx_lvl), .sts_tx_lvl(sts_tx_lvl),
        .irq_evt(irq_evt), .irq(irq0));

    apb_cfg_regs #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .WAIT_STATES(2)) dut2 (
        .clk(clk), .preset_n(preset_n), .apb(bus2),
        .ctrl_size(size2), .ctrl_offset(offset2), .ctrl_clr(clr2),
        .sts_cnt_drop(sts_cnt_drop), .sts_rx_lvl(sts_rx_lvl), .sts_tx_lvl(sts_tx_lvl),
        .irq_evt(irq_evt), .irq(irq2));

    apb_cfg_regs #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .WAIT_STATES(3)) dut3 (
        .clk(clk), .preset_n(preset_n), .apb(bus3),
        .ctrl_size(size3), .ctrl_offset(offset3), .ctrl_clr(clr3),
        .sts_cnt_drop(sts_cnt_drop), .sts_rx_lvl(sts_rx_lvl), .sts_tx_lvl(sts_tx_lvl),
        .irq_evt(irq_evt), .irq(irq3));

    // Observed outputs of the currently selected instance
    logic        s_pready, s_pslverr, s_clr, s_irq;
    logic [31:0] s_prdata;
    logic [2:0]  s_size;
    logic [1:0]  s_offset;

    always_comb begin
        case (dut_sel)
            2: begin
                s_pready = bus2.pready; s_pslverr = bus2.pslverr; s_prdata = bus2.prdata;
                s_size = size2; s_offset = offset2; s_clr = clr2; s_irq = irq2;
            end
            3: begin
                s_pready = bus3.pready; s_pslverr = bus3.pslverr; s_prdata = bus3.prdata;
                s_size = size3; s_offset = offset3; s_clr = clr3; s_irq = irq3;
            end
            default: begin
                s_pready = bus0.pready; s_pslverr = bus0.pslverr; s_prdata = bus0.prdata;
                s_size = size0; s_offset = offset0; s_clr = clr0; s_irq = irq0;
            end
        endcase
    end

    // One APB transfer. Entered just after a rising edge; returns just after
    // the rising edge that follows the pready cycle, with the bus idle.
    // cycles = number of access cycles up to and including pready (-1 on timeout).
    task automatic apb_xfer(input int sel, input logic wr, input logic [15:0] addr,
                            input logic [31:0] wdata, input logic mutate_sts,
                            output logic [31:0] rdata, output logic err, output int cycles);
        logic got;
        got = 1'b0;
        dut_sel = sel;
        m_paddr = addr; m_pwrite = wr; m_pwdata = wdata;
        m_psel = 1'b1; m_penable = 1'b0;
        @(posedge clk); #1;
        m_penable = 1'b1;
        if (mutate_sts) begin
            sts_cnt_drop = 8'hFF; sts_rx_lvl = 4'h0; sts_tx_lvl = 4'h0;
        end
        cycles = 0; rdata = '0; err = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            cycles = cycles + 1;
            @(negedge clk);
            if (s_pready === 1'b1) begin
                got = 1'b1;
                rdata = s_prdata;
                err = s_pslverr;
            end else begin
                @(posedge clk); #1;
            end
        end
        if (!got) cycles = -1;
        @(posedge clk); #1;
        m_psel = 1'b0; m_penable = 1'b0;
        $display("xfer dut%0d %s addr=%h wdata=%h -> rdata=%h err=%0b cycles=%0d",
                 sel, wr ? "WR" : "RD", addr, wdata, rdata, err, cycles);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        dut_sel = 0;
        checks++; if (s_pready !== 1'b0) begin errors++; $display("FAIL reset_pready got %b exp 0", s_pready); end
        checks++; if (s_prdata !== 32'h0) begin errors++; $display("FAIL reset_prdata got %h exp 0", s_prdata); end
        checks++; if (s_pslverr !== 1'b0) begin errors++; $display("FAIL reset_pslverr got %b exp 0", s_pslverr); end
        checks++; if (s_size !== 3'd1) begin errors++; $display("FAIL reset_size got %0d exp 1", s_size); end
        checks++; if (s_offset !== 2'd0) begin errors++; $display("FAIL reset_offset got %0d exp 0", s_offset); end
        checks++; if (s_clr !== 1'b0) begin errors++; $display("FAIL reset_clr got %b exp 0", s_clr); end
        checks++; if (s_irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", s_irq); end
        checks++; if (size3 !== 3'd1) begin errors++; $display("FAIL reset_size_dut3 got %0d exp 1", size3); end
    endtask

    task automatic test_ctrl_write();
        logic [31:0] rd; logic err; int cy;
        apb_xfer(0, 1'b1, 16'h0000, 32'h0001_0102, 1'b0, rd, err, cy);
        checks++; if (cy !== 1) begin errors++; $display("FAIL ctrl_wr_cycles got %0d exp 1", cy); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL ctrl_wr_err got %b exp 0", err); end
        checks++; if (s_pready !== 1'b0) begin errors++; $display("FAIL ctrl_wr_pready_width got %b exp 0", s_pready); end
        checks++; if (s_size !== 3'd2) begin errors++; $display("FAIL ctrl_size got %0d exp 2", s_size); end
        checks++; if (s_offset !== 2'd1) begin errors++; $display("FAIL ctrl_offset got %0d exp 1", s_offset); end
        checks++; if (s_clr !== 1'b1) begin errors++; $display("FAIL ctrl_clr_pulse got %b exp 1", s_clr); end
        idle(1);
        checks++; if (s_clr !== 1'b0) begin errors++; $display("FAIL ctrl_clr_end got %b exp 0", s_clr); end
        apb_xfer(0, 1'b0, 16'h0000, 32'h0, 1'b0, rd, err, cy);
        checks++; if (rd !== 32'h0000_0102) begin errors++; $display("FAIL ctrl_readback got %h exp 00000102", rd); end
        checks++; if (s_prdata !== 32'h0) begin errors++; $display("FAIL prdata_after_ready got %h exp 0", s_prdata); end
    endtask

    task automatic test_errors();
        logic        wr_v   [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [15:0] addr_v [7] = '{16'h000C, 16'h0008, 16'h0000, 16'h0000, 16'h0000, 16'h1000, 16'h0004};
        logic [31:0] data_v [7] = '{32'hFFFF_FFFF, 32'h0, 32'h0000_0100, 32'h0000_0203,
                                    32'h0001_0000, 32'h0, 32'h0000_0001};
        logic [31:0] rd; logic err; int cy;
        for (int i = 0; i < 7; i++) begin
            apb_xfer(0, wr_v[i], addr_v[i], data_v[i], 1'b0, rd, err, cy);
            checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_resp[%0d] got %b exp 1", i, err); end
            checks++; if (rd !== 32'h0) begin errors++; $display("FAIL err_rdata[%0d] got %h exp 0", i, rd); end
            checks++; if (s_clr !== 1'b0) begin errors++; $display("FAIL err_clr[%0d] got %b exp 0", i, s_clr); end
        end
        apb_xfer(0, 1'b0, 16'h0000, 32'h0, 1'b0, rd, err, cy);
        checks++; if (rd !== 32'h0000_0102) begin errors++; $display("FAIL err_ctrl_unchanged got %h exp 00000102", rd); end
        // Legal boundaries: SIZE=4 OFFSET=0 and SIZE=1 OFFSET=3 both sum to 4
        apb_xfer(0, 1'b1, 16'h0000, 32'h0000_0004, 1'b0, rd, err, cy);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL ctrl_size4_err got %b exp 0", err); end
        checks++; if (s_size !== 3'd4) begin errors++; $display("FAIL ctrl_size4 got %0d exp 4", s_size); end
        apb_xfer(0, 1'b1, 16'h0000, 32'h0000_0301, 1'b0, rd, err, cy);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL ctrl_off3_err got %b exp 0", err); end
        apb_xfer(0, 1'b0, 16'h0000, 32'h0, 1'b0, rd, err, cy);
        checks++; if (rd !== 32'h0000_0301) begin errors++; $display("FAIL ctrl_off3_read got %h exp 00000301", rd); end
    endtask

    task automatic test_status();
        logic [31:0] rd; logic err; int cy;
        sts_cnt_drop = 8'h5A; sts_rx_lvl = 4'h3; sts_tx_lvl = 4'h7;
        apb_xfer(3, 1'b0, 16'h000C, 32'h0, 1'b1, rd, err, cy);
        checks++; if (cy !== 4) begin errors++; $display("FAIL status_cycles got %0d exp 4", cy); end
        checks++; if (rd !== 32'h0700_035A) begin errors++; $display("FAIL status_data got %h exp 0700035a", rd); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL status_err got %b exp 0", err); end
        apb_xfer(3, 1'b1, 16'h0000, 32'h0000_0003, 1'b0, rd, err, cy);
        checks++; if (cy !== 4) begin errors++; $display("FAIL ws3_write_cycles got %0d exp 4", cy); end
        checks++; if (s_size !== 3'd3) begin errors++; $display("FAIL ws3_size got %0d exp 3", s_size); end
    endtask

    task automatic test_irq();
        logic [31:0] rd; logic err; int cy;
        // Event on a disabled source: flag set, no interrupt
        irq_evt = 5'b01000; idle(1); irq_evt = 5'b0; idle(2);
        dut_sel = 0;
        checks++; if (s_irq !== 1'b0) begin errors++; $display("FAIL irq_masked got %b exp 0", s_irq); end
        apb_xfer(0, 1'b0, 16'h00F4, 32'h0, 1'b0, rd, err, cy);
        checks++; if (rd !== 32'h0000_0008) begin errors++; $display("FAIL irq_flag3 got %h exp 00000008", rd); end
        apb_xfer(0, 1'b1, 16'h00F4, 32'h0000_0008, 1'b0, rd, err, cy);
        apb_xfer(0, 1'b1, 16'h00F0, 32'h0000_0001, 1'b0, rd, err, cy);
        apb_xfer(0, 1'b0, 16'h00F4, 32'h0, 1'b0, rd, err, cy);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL irq_w1c3 got %h exp 0", rd); end
        // Enabled event: flag next cycle, irq one cycle later
        irq_evt = 5'b00001; idle(1); irq_evt = 5'b0;
        checks++; if (s_irq !== 1'b0) begin errors++; $display("FAIL irq_latency got %b exp 0", s_irq); end
        idle(1);
        checks++; if (s_irq !== 1'b1) begin errors++; $display("FAIL irq_assert got %b exp 1", s_irq); end
        apb_xfer(0, 1'b0, 16'h00F4, 32'h0, 1'b0, rd, err, cy);
        checks++; if (rd !== 32'h0000_0001) begin errors++; $display("FAIL irq_flag0 got %h exp 00000001", rd); end
        // W1C colliding with a new event: set wins
        m_paddr = 16'h00F4; m_pwrite = 1'b1; m_pwdata = 32'h1; m_psel = 1'b1; m_penable = 1'b0;
        @(posedge clk); #1;
        m_penable = 1'b1; irq_evt = 5'b00001;
        @(negedge clk);
        checks++; if (s_pready !== 1'b1) begin errors++; $display("FAIL irq_collide_pready got %b exp 1", s_pready); end
        @(posedge clk); #1;
        m_psel = 1'b0; m_penable = 1'b0; irq_evt = 5'b0;
        $display("xfer dut0 WR addr=00f4 wdata=00000001 with irq_evt[0] same cycle");
        apb_xfer(0, 1'b0, 16'h00F4, 32'h0, 1'b0, rd, err, cy);
        checks++; if (rd !== 32'h0000_0001) begin errors++; $display("FAIL irq_set_wins got %h exp 00000001", rd); end
        checks++; if (s_irq !== 1'b1) begin errors++; $display("FAIL irq_still_high got %b exp 1", s_irq); end
        apb_xfer(0, 1'b1, 16'h00F4, 32'h0000_0001, 1'b0, rd, err, cy);
        idle(1);
        checks++; if (s_irq !== 1'b0) begin errors++; $display("FAIL irq_cleared got %b exp 0", s_irq); end
        apb_xfer(0, 1'b0, 16'h00F4, 32'h0, 1'b0, rd, err, cy);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL irq_flag_clear got %h exp 0", rd); end
    endtask

    task automatic test_abort();
        logic [31:0] rd; logic err; int cy;
        dut_sel = 2;
        m_paddr = 16'h00F0; m_pwrite = 1'b1; m_pwdata = 32'h0000_001F; m_psel = 1'b1; m_penable = 1'b0;
        @(posedge clk); #1;
        m_penable = 1'b1;
        @(negedge clk);
        checks++; if (s_pready !== 1'b0) begin errors++; $display("FAIL abort_early_ready got %b exp 0", s_pready); end
        @(posedge clk); #1;
        m_psel = 1'b0; m_penable = 1'b0;
        $display("xfer dut2 WR addr=00f0 wdata=0000001f aborted after access cycle 1");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (s_pready !== 1'b0) begin errors++; $display("FAIL abort_ready[%0d] got %b exp 0", i, s_pready); end
        end
        @(posedge clk); #1;
        apb_xfer(2, 1'b0, 16'h00F0, 32'h0, 1'b0, rd, err, cy);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL abort_irqen got %h exp 0", rd); end
        checks++; if (cy !== 3) begin errors++; $display("FAIL ws2_cycles got %0d exp 3", cy); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic err; int cy1, cy2, t0;
        t0 = cyc;
        apb_xfer(0, 1'b1, 16'h0000, 32'h0000_0103, 1'b0, rd, err, cy1);
        apb_xfer(0, 1'b0, 16'h0000, 32'h0, 1'b0, rd, err, cy2);
        checks++; if (cy1 !== 1 || cy2 !== 1) begin errors++; $display("FAIL b2b_cycles got %0d/%0d exp 1/1", cy1, cy2); end
        checks++; if (rd !== 32'h0000_0103) begin errors++; $display("FAIL b2b_read got %h exp 00000103", rd); end
        checks++; if (cyc - t0 !== 4) begin errors++; $display("FAIL b2b_elapsed got %0d exp 4", cyc - t0); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic err; int cy;
        irq_evt = 5'b00001; idle(1); irq_evt = 5'b0; idle(1);
        dut_sel = 0;
        checks++; if (s_irq !== 1'b1) begin errors++; $display("FAIL pre_reset_irq got %b exp 1", s_irq); end
        m_paddr = 16'h0000; m_pwrite = 1'b1; m_pwdata = 32'h0001_0202; m_psel = 1'b1; m_penable = 1'b0;
        @(posedge clk); #1;
        m_penable = 1'b1;
        #1 preset_n = 1'b0;
        #1;
        $display("xfer dut0 WR addr=0000 wdata=00010202 reset during access");
        checks++; if (s_pready !== 1'b0) begin errors++; $display("FAIL rst_mid_pready got %b exp 0", s_pready); end
        checks++; if (s_size !== 3'd1) begin errors++; $display("FAIL rst_mid_size got %0d exp 1", s_size); end
        checks++; if (s_offset !== 2'd0) begin errors++; $display("FAIL rst_mid_offset got %0d exp 0", s_offset); end
        checks++; if (s_irq !== 1'b0) begin errors++; $display("FAIL rst_mid_irq got %b exp 0", s_irq); end
        checks++; if (s_clr !== 1'b0 || s_pslverr !== 1'b0 || s_prdata !== 32'h0) begin
            errors++; $display("FAIL rst_mid_misc got clr=%b err=%b rdata=%h exp 0", s_clr, s_pslverr, s_prdata);
        end
        @(posedge clk); #1;
        m_psel = 1'b0; m_penable = 1'b0;
        @(posedge clk); #1;
        preset_n = 1'b1;
        idle(1);
        checks++; if (s_clr !== 1'b0 || s_size !== 3'd1) begin
            errors++; $display("FAIL rst_post got clr=%b size=%0d exp 0/1", s_clr, s_size);
        end
        apb_xfer(0, 1'b0, 16'h0000, 32'h0, 1'b0, rd, err, cy);
        checks++; if (rd !== 32'h0000_0001) begin errors++; $display("FAIL rst_ctrl_read got %h exp 00000001", rd); end
        apb_xfer(0, 1'b0, 16'h00F0, 32'h0, 1'b0, rd, err, cy);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_irqen_read got %h exp 0", rd); end
        apb_xfer(0, 1'b0, 16'h00F4, 32'h0, 1'b0, rd, err, cy);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_irq_read got %h exp 0", rd); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        preset_n = 1'b0;
        m_paddr = '0; m_psel = 1'b0; m_penable = 1'b0; m_pwrite = 1'b0; m_pwdata = '0;
        sts_cnt_drop = '0; sts_rx_lvl = '0; sts_tx_lvl = '0; irq_evt = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        preset_n = 1'b1;
        idle(2);
        test_ctrl_write();
        test_errors();
        test_status();
        test_irq();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
